// File: rtl/kyber_pkg.sv
// kyber_pkg
//   Shared Kyber constants and types used by the coefficient-scaling blocks.
//   KYBER_Q        : the Kyber modulus q = 3329.
//   KYBER_HALF_QP1 : (q + 1) / 2, the modular inverse of 2.
//   state_t        : sequencer states IDLE / ITER / DONE.
//   reduce_once()  : one conditional subtraction of q; any 12-bit value is
//                    below 2q, so the result is always fully reduced.
package kyber_pkg;

  localparam logic [11:0] KYBER_Q        = 12'd3329;
  localparam logic [10:0] KYBER_HALF_QP1 = 11'd1665;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [11:0] reduce_once(input logic [11:0] x);
    logic [11:0] r;
    r = (x >= KYBER_Q) ? (x - KYBER_Q) : x;
    return r;
  endfunction

endpackage

// File: rtl/halve_seq_div2.sv
// div2
//   Combinational modular halving in Z_q, q = 3329.
//   y = x / 2 mod q = (x >> 1) + (x odd ? (q + 1) / 2 : 0).
//   For x < q the result is < q, so no further reduction is needed.
// Ports:
//   i_x : 12-bit operand, must be < 3329
//   o_y : 12-bit result,  < 3329
module div2
  import kyber_pkg::*;
(
  input  logic [11:0] i_x,
  output logic [11:0] o_y
);

  logic [11:0] w_shift;
  logic [11:0] w_addend;

  always_comb begin
    w_shift  = {1'b0, i_x[11:1]};
    w_addend = i_x[0] ? {1'b0, KYBER_HALF_QP1} : '0;
    o_y      = w_shift + w_addend;
  end

endmodule

// File: rtl/halve_seq.sv
// halve_seq
//   Iterative modular-halving sequencer for Kyber coefficients (q = 3329).
//   Accepts one 12-bit coefficient and a halving count k, then applies the
//   shared div2 unit once per cycle for k cycles, producing
//   out_data = in_data * 2^-k mod q.
//
// Parameters:
//   CNT_W     : width of the halving count, k in 0 .. 2^CNT_W-1
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : coefficient and count offered
//   in_ready  : offer accepted this cycle
//   in_data   : coefficient 0..4095 (reduced mod q at load)
//   in_cnt    : number of halvings k
//   out_valid : result held on out_data
//   out_ready : consumer takes the result
//   out_data  : result, always < 3329
//   busy      : block is not in IDLE
//
// Configuration macro:
//   HALVE_SEQ_OVERLAP_EN : when defined, in DONE in_ready follows out_ready so
//                          a new job loads on the same edge the result leaves.
module halve_seq
  import kyber_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_data,
  input  logic [CNT_W-1:0] in_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      out_data,
  output logic             busy
);

  state_t           r_state;
  logic [11:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [11:0]      r_out_data;

  logic [11:0]      w_load_acc;
  logic [11:0]      w_next_acc;
  logic             w_in_ready;
  logic             w_cnt_zero_in;
  logic             w_last_iter;

  div2 u_div2 (
    .i_x (r_acc),
    .o_y (w_next_acc)
  );

  always_comb begin
    w_load_acc    = reduce_once(in_data);
    w_cnt_zero_in = (in_cnt == '0);
    w_last_iter   = (r_cnt == CNT_W'(1));
  end

  always_comb begin
    w_in_ready = (r_state == IDLE);
`ifdef HALVE_SEQ_OVERLAP_EN
    if (r_state == DONE) begin
      w_in_ready = out_ready;
    end
`endif
  end

  // out_data is loaded on the edge that enters DONE, so it equals acc
  // throughout DONE and holds its value in every other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc <= w_load_acc;
            r_cnt <= in_cnt;
            if (w_cnt_zero_in) begin
              r_state    <= DONE;
              r_out_data <= w_load_acc;
            end else begin
              r_state <= ITER;
            end
          end
        end

        ITER: begin
          r_acc <= w_next_acc;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last_iter) begin
            r_state    <= DONE;
            r_out_data <= w_next_acc;
          end
        end

        DONE: begin
          if (out_ready) begin
`ifdef HALVE_SEQ_OVERLAP_EN
            // Output and input handshakes on one edge: retire the result
            // and start the next job without passing through IDLE.
            if (in_valid) begin
              r_acc <= w_load_acc;
              r_cnt <= in_cnt;
              if (w_cnt_zero_in) begin
                r_state    <= DONE;
                r_out_data <= w_load_acc;
              end else begin
                r_state <= ITER;
              end
            end else begin
              r_state <= IDLE;
            end
`else
            r_state <= IDLE;
`endif
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == DONE);
  assign out_data  = r_out_data;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_halve_seq.sv
module tb_halve_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic [2:0]  in_cnt;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic        busy;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  halve_seq #(.CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] data;
    logic [2:0]  cnt;
    logic [11:0] exp;
  } vec_t;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: (d mod q) * inv(2)^k mod q, using the multiplicative inverse.
  function automatic int unsigned model(input int unsigned d, input int unsigned k);
    int unsigned x;
    x = d % 3329;
    for (int unsigned i = 0; i < k; i++) x = (x * 1665) % 3329;
    return x;
  endfunction

  // Offer one job with out_ready high; check result and latency (k + 1).
  task automatic run_job(input logic [11:0] d, input logic [2:0] k, input logic [11:0] exp,
                         input string name);
    int unsigned lat;
    @(negedge clk);
    in_data  = d;
    in_cnt   = k;
    in_valid = 1'b1;
    out_ready = 1'b1;
    chk({name, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, k + 1);
    chk({name, "_data"}, out_data, exp);
    chk({name, "_lt_q"}, (out_data < 12'd3329), 1);
    @(posedge clk); #1;
    chk({name, "_vld_drop"}, out_valid, 0);
  endtask

  vec_t vecs[12];

  initial begin
    int unsigned lat;
    logic [11:0] held;

    vecs[0]  = '{12'd1,    3'd1, 12'd1665};
    vecs[1]  = '{12'd1,    3'd2, 12'd2497};
    vecs[2]  = '{12'd3330, 3'd1, 12'd1665};
    vecs[3]  = '{12'd3328, 3'd0, 12'd3328};
    vecs[4]  = '{12'd0,    3'd5, 12'd0};
    vecs[5]  = '{12'd4095, 3'd0, 12'd766};
    vecs[6]  = '{12'd4095, 3'd1, 12'd383};
    vecs[7]  = '{12'd3328, 3'd1, 12'd1664};
    vecs[8]  = '{12'd3,    3'd1, 12'd1666};
    vecs[9]  = '{12'd5,    3'd3, 12'd1249};
    vecs[10] = '{12'd3329, 3'd3, 12'd0};
    vecs[11] = '{12'd7,    3'd2, 12'd834};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_cnt = '0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_busy",      busy,      0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_job(vecs[i].data, vecs[i].cnt, vecs[i].exp, $sformatf("vec%0d", i));

    // 128 halved 7 times; in_ready low and busy high through every ITER cycle.
    @(negedge clk);
    in_data = 12'd128; in_cnt = 3'd7; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!out_valid && lat < 30) begin
      chk("iter_in_ready", in_ready, 0);
      chk("iter_busy", busy, 1);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("k7_latency", lat, 8);
    chk("k7_data", out_data, 1);
    @(posedge clk); #1;

    // Back-pressure: result held 5 cycles while a second job waits.
    out_ready = 1'b0;
    @(negedge clk);
    in_data = 12'd5; in_cnt = 3'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 12'd7; in_cnt = 3'd2;
    lat = 1;
    while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    chk("hold_latency", lat, 4);
    held = out_data;
    chk("hold_first", held, 1249);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, 1249);
      chk("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
`ifdef HALVE_SEQ_OVERLAP_EN
    chk("ovl_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ovl_vld_drop", out_valid, 0);
    chk("ovl_busy", busy, 1);
    lat = 1;
`else
    @(posedge clk); #1;
    chk("nov_vld_drop", out_valid, 0);
    chk("nov_busy", busy, 0);
    chk("nov_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
`endif
    while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    chk("second_latency", lat, 3);
    chk("second_data", out_data, 834);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of ITER discards the job.
    @(negedge clk);
    in_data = 12'd2; in_cnt = 3'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(12'd2, 3'd1, 12'd1, "post_rst");

    // Random sweep against the multiplicative model.
    for (int i = 0; i < 40; i++) begin
      logic [11:0] d;
      logic [2:0]  k;
      d = 12'($urandom_range(0, 4095));
      k = 3'($urandom_range(0, 7));
      run_job(d, k, 12'(model(d, k)), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
